serial_sub_16bit: RTL and testbench
===================================

SERIAL_SUB_16BIT -- requirements
Module: serial_sub_16bit

Interface
REQ-001 Parameter: DIGIT_W, default 1, bits processed per RUN cycle; legal values 1, 2, 4, 8, 16.
REQ-002 Derived constant: N = 16/DIGIT_W, the number of RUN cycles per operation.
REQ-003 Reset is rst, asynchronous, active-high; the clock is clk.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  request; sampled only in IDLE.
REQ-007 in_a  in  16  minuend, captured on the accepting edge.
REQ-008 in_b  in  16  subtrahend, captured on the accepting edge.
REQ-009 bin  in  1  borrow-in, captured on the accepting edge.
REQ-010 busy  out  1  high while state is RUN.
REQ-011 done  out  1  one-cycle pulse, high while state is DONE.
REQ-012 diff  out  16  registered difference.
REQ-013 bout  out  1  registered borrow-out.
REQ-014 zero  out  1  registered flag, high when diff == 0.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 IDLE SHALL move to RUN on a rising edge with start=1, and SHALL stay in IDLE otherwise.
REQ-017 RUN SHALL move to DONE on its Nth edge.
REQ-018 DONE SHALL move unconditionally to IDLE on the next edge.
REQ-019 On the accepting edge the block SHALL capture in_a, in_b and bin into internal shift registers; input changes afterwards SHALL have no effect.
REQ-020 Each RUN edge SHALL subtract the DIGIT_W least-significant bits of the a/b shift registers with the running borrow, shift the result digit into the result register, and shift a/b right by DIGIT_W.
REQ-021 The running borrow SHALL start at the captured bin.
REQ-022 The result SHALL satisfy {bout,diff} = ({1'b0,a} - {1'b0,b} - bin) mod 2^17, so bout=1 exactly when a < b + bin (unsigned).
REQ-023 On the edge entering DONE, diff, bout and zero SHALL be loaded together.
REQ-024 diff, bout and zero SHALL hold their values until the next DONE load; intermediate digits SHALL never be visible on diff.
REQ-025 Latency: if start is accepted at edge k, done SHALL be high during the cycle after edge k+N and low again after edge k+N+1.
REQ-026 The earliest next acceptance SHALL be edge k+N+2, giving a throughput of one operation per N+2 cycles.
REQ-027 start SHALL be ignored in RUN and in DONE; no request is queued.
REQ-028 busy and done SHALL never be high in the same cycle.
REQ-029 With DIGIT_W=16, RUN SHALL last exactly one cycle and all timing rules above SHALL still hold.

Reset
REQ-030 While rst=1, state SHALL be IDLE and busy, done, diff, bout and zero SHALL all be 0, including zero=0.
REQ-031 The shift registers and borrow SHALL clear to 0 while rst=1.
REQ-032 rst asserted during RUN or DONE SHALL abort the operation: no done pulse, and diff/bout SHALL NOT be updated afterwards from the aborted operation.
REQ-033 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-034 DIGIT_W=1, start with a=0x0000, b=0x0000, bin=0 -> done exactly 16 edges after acceptance; diff=0x0000, bout=0, zero=1.
REQ-035 a=0x0000, b=0x0000, bin=1 -> diff=0xFFFF, bout=1, zero=0; a=0xFFFF, b=0x0000, bin=1 -> diff=0xFFFE, bout=0.
REQ-036 a=0x0001, b=0x0002, bin=0 -> diff=0xFFFF, bout=1; then a=0x1234, b=0x1234, bin=0 -> diff=0x0000, bout=0, zero=1.
REQ-037 Start a=0x0005, b=0x0003, bin=0, then pulse start with a=0xFFFF, b=0x0001 during RUN and again during DONE -> exactly one done pulse, diff=0x0002; busy=0 when done=1.
REQ-038 Load diff=0x0002, then start a=0x00FF, b=0x0001 and assert rst 5 cycles into RUN -> busy=0 and diff=0 immediately, no done pulse; the next start with a=0x0003, b=0x0001 gives diff=0x0002 16 edges later.
REQ-039 DIGIT_W=4 and DIGIT_W=16, a=0x8000, b=0x0001, bin=1 -> diff=0x7FFE, bout=0; done 4 edges and 1 edge after acceptance respectively.

Source files
------------

// File: rtl/serial_sub_16bit.sv
// serial_sub_16bit: digit-serial 16-bit subtractor with borrow-in/borrow-out and zero flag
module serial_sub_16bit #(
   parameter int DIGIT_W = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   input  logic        bin,
   output logic        busy,
   output logic        done,
   output logic [15:0] diff,
   output logic        bout,
   output logic        zero
);
   localparam int N = 16 / DIGIT_W;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t             state, state_nx;
   logic [15:0]        a_sr, b_sr, r_sr, r_nx;
   logic               borrow, br_nx, last;
   logic [4:0]         cnt;
   logic [DIGIT_W-1:0] dig;
   assign last = cnt == 5'(N - 1);
   assign busy = state == RUN;
   assign done = state == DONE;
   // accept only from IDLE; RUN lasts N edges; DONE is a single-cycle pulse
   always_comb begin
      state_nx = (state == IDLE) ? (start ? RUN : IDLE) : (state == RUN) ? (last ? DONE : RUN) : IDLE;
   end
   // subtract the low digit with the running borrow; the borrow is the top bit of the wrapped result
   always_comb begin
      {br_nx, dig} = {1'b0, a_sr[DIGIT_W-1:0]} - {1'b0, b_sr[DIGIT_W-1:0]} - {{DIGIT_W{1'b0}}, borrow};
   end
   if (DIGIT_W == 16) begin : g_full
      assign r_nx = dig;
   end else begin : g_part
      assign r_nx = {dig, r_sr[15:DIGIT_W]};
   end
   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   // operand/result shifting; outputs load only on the final RUN edge so partial digits stay hidden
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         r_sr   <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         bout   <= 1'b0;
         zero   <= 1'b0;
      end else if (state == IDLE && start) begin
         a_sr   <= in_a;
         b_sr   <= in_b;
         r_sr   <= '0;
         borrow <= bin;
         cnt    <= '0;
      end else if (state == RUN) begin
         a_sr   <= a_sr >> DIGIT_W;
         b_sr   <= b_sr >> DIGIT_W;
         r_sr   <= r_nx;
         borrow <= br_nx;
         cnt    <= cnt + 5'd1;
         if (last) begin
            diff <= r_nx;
            bout <= br_nx;
            zero <= r_nx == 16'd0;
         end
      end
   end
endmodule

// File: tb/tb_serial_sub_16bit.sv
// tb_serial_sub_16bit: directed checks of the serial subtractor at digit widths 1, 4 and 16
module tb_serial_sub_16bit;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, bin = 1'b0;
   logic [15:0] in_a = '0, in_b = '0;
   logic        busy1, done1, bout1, zero1, busy4, done4, bout4, zero4, busy16, done16, bout16, zero16;
   logic [15:0] diff1, diff4, diff16;
   int          n_cmp = 0, n_bad = 0;
   int          lat;

   serial_sub_16bit #(.DIGIT_W(1)) dut1 (.clk(clk), .rst(rst), .start(start), .in_a(in_a), .in_b(in_b), .bin(bin),
      .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .zero(zero1));
   serial_sub_16bit #(.DIGIT_W(4)) dut4 (.clk(clk), .rst(rst), .start(start), .in_a(in_a), .in_b(in_b), .bin(bin),
      .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4));
   serial_sub_16bit #(.DIGIT_W(16)) dut16 (.clk(clk), .rst(rst), .start(start), .in_a(in_a), .in_b(in_b), .bin(bin),
      .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .zero(zero16));

   always #5 clk = ~clk;

   // launch one operation and return the number of edges after acceptance until dut1 shows done
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi, output int l);
      @(negedge clk); in_a = a; in_b = b; bin = bi; start = 1'b1;
      @(posedge clk); @(negedge clk); start = 1'b0;
      l = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); @(negedge clk);
         if (done1) begin l = i; break; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy1); end
      n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done1); end
      n_cmp++; if ({bout1, diff1} !== 17'h0) begin n_bad++; $display("FAIL reset_diff got %h want 00000", {bout1, diff1}); end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (zero1 !== 1'b0) begin n_bad++; $display("FAIL reset_zero got %b want 0", zero1); end
   endtask

   task automatic test_basic;
      run_op(16'h0000, 16'h0000, 1'b0, lat);
      n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL basic_latency got %0d want 16", lat); end
      n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done got %b want 0", busy1); end
      n_cmp++; if ({bout1, diff1, zero1} !== 18'h00001) begin n_bad++; $display("FAIL basic_result got %b/%h/%b want 0/0000/1", bout1, diff1, zero1); end
      @(posedge clk); @(negedge clk);
      n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL basic_done_width got %b want 0", done1); end
   endtask

   task automatic test_borrow;
      run_op(16'h0000, 16'h0000, 1'b1, lat);
      n_cmp++; if ({bout1, diff1, zero1} !== {1'b1, 16'hFFFF, 1'b0}) begin n_bad++; $display("FAIL borrow_in_zero got %b/%h/%b want 1/ffff/0", bout1, diff1, zero1); end
      run_op(16'hFFFF, 16'h0000, 1'b1, lat);
      n_cmp++; if ({bout1, diff1, zero1} !== {1'b0, 16'hFFFE, 1'b0}) begin n_bad++; $display("FAIL borrow_in_max got %b/%h/%b want 0/fffe/0", bout1, diff1, zero1); end
   endtask

   task automatic test_underflow;
      run_op(16'h0001, 16'h0002, 1'b0, lat);
      n_cmp++; if ({bout1, diff1, zero1} !== {1'b1, 16'hFFFF, 1'b0}) begin n_bad++; $display("FAIL underflow got %b/%h/%b want 1/ffff/0", bout1, diff1, zero1); end
      run_op(16'h1234, 16'h1234, 1'b0, lat);
      n_cmp++; if ({bout1, diff1, zero1} !== {1'b0, 16'h0000, 1'b1}) begin n_bad++; $display("FAIL equal_operands got %b/%h/%b want 0/0000/1", bout1, diff1, zero1); end
      run_op(16'hA5C3, 16'h3C5A, 1'b1, lat);
      n_cmp++; if ({bout1, diff1} !== {1'b0, 16'h6968}) begin n_bad++; $display("FAIL mixed got %b/%h want 0/6968", bout1, diff1); end
   endtask

   task automatic test_ignore_start;
      int pulses;
      pulses = 0;
      @(negedge clk); in_a = 16'h0005; in_b = 16'h0003; bin = 1'b0; start = 1'b1;
      @(posedge clk); @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      in_a = 16'hFFFF; in_b = 16'h0001; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 30 && !done1; i++) @(negedge clk);
      n_cmp++; if (done1 !== 1'b1) begin n_bad++; $display("FAIL ignore_done got %b want 1", done1); end
      n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL ignore_busy_at_done got %b want 0", busy1); end
      n_cmp++; if (diff1 !== 16'h0002) begin n_bad++; $display("FAIL ignore_diff got %h want 0002", diff1); end
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 25; i++) begin @(negedge clk); if (done1 || busy1) pulses++; end
      n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL ignore_no_queue got %0d active cycles want 0", pulses); end
      n_cmp++; if (diff1 !== 16'h0002) begin n_bad++; $display("FAIL ignore_diff_held got %h want 0002", diff1); end
   endtask

   task automatic test_abort;
      int pulses;
      pulses = 0;
      run_op(16'h0005, 16'h0003, 1'b0, lat);
      @(negedge clk); in_a = 16'h00FF; in_b = 16'h0001; start = 1'b1;
      @(posedge clk); @(negedge clk); start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      #1;
      n_cmp++; if ({busy1, done1} !== 2'b00) begin n_bad++; $display("FAIL abort_busy got %b want 00", {busy1, done1}); end
      n_cmp++; if (diff1 !== 16'h0000) begin n_bad++; $display("FAIL abort_diff got %h want 0000", diff1); end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 20; i++) begin @(negedge clk); if (done1) pulses++; end
      n_cmp++; if (pulses !== 0 || diff1 !== 16'h0000) begin n_bad++; $display("FAIL abort_no_done got %0d pulses diff %h want 0 pulses diff 0000", pulses, diff1); end
      run_op(16'h0003, 16'h0001, 1'b0, lat);
      n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL abort_restart_latency got %0d want 16", lat); end
      n_cmp++; if (diff1 !== 16'h0002) begin n_bad++; $display("FAIL abort_restart_diff got %h want 0002", diff1); end
   endtask

   task automatic test_digit_widths;
      int l1, l4, l16;
      l1 = -1; l4 = -1; l16 = -1;
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      in_a = 16'h8000; in_b = 16'h0001; bin = 1'b1; start = 1'b1;
      @(posedge clk); @(negedge clk); start = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); @(negedge clk);
         if (done1 && l1 < 0) l1 = i;
         if (done4 && l4 < 0) l4 = i;
         if (done16 && l16 < 0) l16 = i;
      end
      n_cmp++; if (l1 !== 16) begin n_bad++; $display("FAIL w1_latency got %0d want 16", l1); end
      n_cmp++; if (l4 !== 4) begin n_bad++; $display("FAIL w4_latency got %0d want 4", l4); end
      n_cmp++; if (l16 !== 1) begin n_bad++; $display("FAIL w16_latency got %0d want 1", l16); end
      n_cmp++; if ({bout1, diff1} !== {1'b0, 16'h7FFE}) begin n_bad++; $display("FAIL w1_result got %b/%h want 0/7ffe", bout1, diff1); end
      n_cmp++; if ({bout4, diff4, zero4} !== {1'b0, 16'h7FFE, 1'b0}) begin n_bad++; $display("FAIL w4_result got %b/%h/%b want 0/7ffe/0", bout4, diff4, zero4); end
      n_cmp++; if ({bout16, diff16, zero16} !== {1'b0, 16'h7FFE, 1'b0}) begin n_bad++; $display("FAIL w16_result got %b/%h/%b want 0/7ffe/0", bout16, diff16, zero16); end
      n_cmp++; if ({busy4, busy16} !== 2'b00) begin n_bad++; $display("FAIL wide_idle got %b want 00", {busy4, busy16}); end
   endtask

   task automatic test_back_to_back;
      run_op(16'h0009, 16'h0001, 1'b0, lat);
      in_a = 16'h0007; in_b = 16'h0002; bin = 1'b0; start = 1'b1;
      @(posedge clk); @(negedge clk);
      n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL b2b_done_ignores got busy %b want 0", busy1); end
      @(posedge clk); @(negedge clk); start = 1'b0;
      n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL b2b_accept got busy %b want 1", busy1); end
      n_cmp++; if (diff1 !== 16'h0008) begin n_bad++; $display("FAIL b2b_first_diff got %h want 0008", diff1); end
      lat = -1;
      for (int i = 1; i <= 40; i++) begin @(posedge clk); @(negedge clk); if (done1) begin lat = i; break; end end
      n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL b2b_latency got %0d want 16", lat); end
      n_cmp++; if (diff1 !== 16'h0005) begin n_bad++; $display("FAIL b2b_second_diff got %h want 0005", diff1); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_borrow;
      test_underflow;
      test_ignore_start;
      test_abort;
      test_digit_widths;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
